// File: rtl/fir_filter_mc.sv
// Signed direct-form FIR over NUM_CH interleaved channels. All channels share one
// double-buffered (shadow/active) coefficient bank. Fixed two-cycle latency.
module fir_filter_mc #(
  parameter int DATA_W = 19,
  parameter int COEF_W = 13,
  parameter int TAPS   = 16,
  parameter int NUM_CH = 1,
  parameter int CH_W   = 1,
  parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS),
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] FilterIn,
  input  logic                     ValidIn,
  input  logic [CH_W-1:0]          ChanIn,
  input  logic                     CoefWrEn,
  input  logic [AW-1:0]            CoefAddr,
  input  logic signed [COEF_W-1:0] CoefData,
  input  logic                     CoefCommit,
  output logic signed [OUT_W-1:0]  FilterOut,
  output logic                     ValidOut,
  output logic [CH_W-1:0]          ChanOut
);
  localparam int PW = DATA_W + COEF_W;

  logic signed [DATA_W-1:0] r_line [NUM_CH][TAPS];
  logic signed [COEF_W-1:0] r_shadow [TAPS];
  logic signed [COEF_W-1:0] r_active [TAPS];
  logic signed [COEF_W-1:0] w_shadow_nxt [TAPS];
  logic signed [PW-1:0]     r_prod [TAPS];
  logic signed [OUT_W-1:0]  w_sum;
  logic signed [OUT_W-1:0]  r_out;
  logic                     r_acc_v;
  logic                     r_s1_v;
  logic                     r_vout;
  logic [CH_W-1:0]          r_acc_ch;
  logic [CH_W-1:0]          r_s1_ch;
  logic [CH_W-1:0]          r_chout;
  logic                     w_chan_ok;
  logic                     w_addr_ok;
  logic                     w_accept;

  // Range checks collapse to constants when the index space is fully populated.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_chan_full
      assign w_chan_ok = 1'b1;
    end else begin : g_chan_part
      assign w_chan_ok = (ChanIn < CH_W'(NUM_CH));
    end
    if (TAPS == (1 << AW)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_part
      assign w_addr_ok = (CoefAddr < AW'(TAPS));
    end
  endgenerate

  assign w_accept = ValidIn && w_chan_ok;

  // A commit in the same cycle as a write copies the freshly written value.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_shadow_nxt[k] = r_shadow[k];
      if (CoefWrEn && w_addr_ok && (CoefAddr == AW'(k))) begin
        w_shadow_nxt[k] = CoefData;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + OUT_W'(r_prod[k]);
    end
  end

  // Products are formed one edge after acceptance, so r_active there is the bank
  // as it stood after the accepting edge; a later commit cannot reach back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        for (int k = 0; k < TAPS; k++) begin
          r_line[ch][k] <= '0;
        end
      end
      for (int k = 0; k < TAPS; k++) begin
        r_shadow[k] <= (k == 0) ? COEF_W'(1) : '0;
        r_active[k] <= (k == 0) ? COEF_W'(1) : '0;
        r_prod[k]   <= '0;
      end
      r_acc_v  <= 1'b0;
      r_acc_ch <= '0;
      r_s1_v   <= 1'b0;
      r_s1_ch  <= '0;
      r_vout   <= 1'b0;
      r_out    <= '0;
      r_chout  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_accept && (ChanIn == CH_W'(ch))) begin
          r_line[ch][0] <= FilterIn;
          for (int k = 1; k < TAPS; k++) begin
            r_line[ch][k] <= r_line[ch][k-1];
          end
        end
      end
      for (int k = 0; k < TAPS; k++) begin
        r_shadow[k] <= w_shadow_nxt[k];
        if (CoefCommit) begin
          r_active[k] <= w_shadow_nxt[k];
        end
      end
      r_acc_v <= w_accept;
      if (w_accept) begin
        r_acc_ch <= ChanIn;
      end
      r_s1_v  <= r_acc_v;
      r_s1_ch <= r_acc_ch;
      if (r_acc_v) begin
        for (int k = 0; k < TAPS; k++) begin
          r_prod[k] <= PW'(r_line[r_acc_ch][k]) * PW'(r_active[k]);
        end
      end
      r_vout <= r_s1_v;
      if (r_s1_v) begin
        r_out   <= w_sum;
        r_chout <= r_s1_ch;
      end
    end
  end

  assign FilterOut = r_out;
  assign ValidOut  = r_vout;
  assign ChanOut   = r_chout;

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc: a single-channel and a three-channel instance,
// with expected results queued at drive time and popped when ValidOut rises.
module tb_fir_filter_mc;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [18:0] fin;
  logic               va;
  logic               vb;
  logic               ca;
  logic [1:0]         cb;
  logic               wr;
  logic [3:0]         caddr;
  logic signed [12:0] cdata;
  logic               commit;
  logic signed [35:0] a_fo;
  logic               a_vo;
  logic               a_co;
  logic signed [35:0] b_fo;
  logic               b_vo;
  logic [1:0]         b_co;

  typedef struct {
    int     due;
    int     ch;
    longint val;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   a_vcnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_filter_mc u_a (
    .clk(clk), .rst(rst), .FilterIn(fin), .ValidIn(va), .ChanIn(ca),
    .CoefWrEn(wr), .CoefAddr(caddr), .CoefData(cdata), .CoefCommit(commit),
    .FilterOut(a_fo), .ValidOut(a_vo), .ChanOut(a_co)
  );

  fir_filter_mc #(.NUM_CH(3), .CH_W(2)) u_b (
    .clk(clk), .rst(rst), .FilterIn(fin), .ValidIn(vb), .ChanIn(cb),
    .CoefWrEn(wr), .CoefAddr(caddr), .CoefData(cdata), .CoefCommit(commit),
    .FilterOut(b_fo), .ValidOut(b_vo), .ChanOut(b_co)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_vo !== 1'b0) begin
      a_vcnt++;
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", a_vo, 0);
      end else begin
        e = qa.pop_front();
        chk("a_latency", cyc, e.due);
        chk("a_out", a_fo, e.val);
        chk("a_chan", a_co, e.ch);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_vo !== 1'b0) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", b_vo, 0);
      end else begin
        e = qb.pop_front();
        chk("b_latency", cyc, e.due);
        chk("b_out", b_fo, e.val);
        chk("b_chan", b_co, e.ch);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    va     = 1'b0;
    vb     = 1'b0;
    wr     = 1'b0;
    commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    wr    = 1'b1;
    caddr = 4'(a);
    cdata = 13'(d);
    tick();
  endtask

  task automatic sa(input int x, input longint y);
    fin = 19'(x);
    ca  = 1'b0;
    va  = 1'b1;
    tick();
    qa.push_back(exp_t'{cyc + 2, 0, y});
  endtask

  task automatic sb(input int ch, input int x, input longint y, input bit expect_out);
    fin = 19'(x);
    cb  = 2'(ch);
    vb  = 1'b1;
    tick();
    if (expect_out) qb.push_back(exp_t'{cyc + 2, ch, y});
  endtask

  task automatic drain();
    repeat (4) tick();
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; va = 1'b0; vb = 1'b0; ca = 1'b0; cb = '0; fin = '0;
    wr = 1'b0; caddr = '0; cdata = '0; commit = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_a_fo", a_fo, 0);
    chk("rst_a_vo", a_vo, 0);
    chk("rst_a_co", a_co, 0);
    chk("rst_b_fo", b_fo, 0);
    chk("rst_b_vo", b_vo, 0);
    chk("rst_b_co", b_co, 0);

    // Impulse bank after reset: pass-through, back-to-back
    sa(5, 5);
    sa(-3, -3);
    sa(262143, 262143);
    drain();
    chk("a_valid_cycles", a_vcnt, 3);
    chk("a_hold_fo", a_fo, 262143);
    chk("a_hold_vo", a_vo, 0);

    // Coefficient load and commit
    do_reset();
    wcoef(0, 1);
    wcoef(1, 2);
    wcoef(2, -3);
    commit = 1'b1;
    tick();
    sa(100, 100);
    sa(0, 200);
    sa(0, -300);
    sa(0, 0);
    sa(0, 0);
    drain();

    // Shadow isolation and commit timing
    do_reset();
    wcoef(0, 7);
    sa(4, 4);
    commit = 1'b1;
    sa(4, 28);
    wr = 1'b1; caddr = 4'd0; cdata = 13'sd3; commit = 1'b1;
    sa(5, 15);
    wr = 1'b1; caddr = 4'd1; cdata = 13'sd1;
    sa(2, 6);
    commit = 1'b1;
    tick();
    sa(1, 5);
    drain();

    // Channel isolation on the three-channel instance
    do_reset();
    wcoef(0, 1);
    wcoef(1, 1);
    wcoef(2, 1);
    commit = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      sb(0, 10, (r < 3) ? 10 * (r + 1) : 30, 1'b1);
      sb(1, 0, 0, 1'b1);
      sb(2, 0, 0, 1'b1);
      if (r == 0) begin
        sb(3, 500, 0, 1'b0);
        fin = 19'sd777;
        tick();
      end
    end
    drain();

    // Extreme values: full-scale negative data and coefficients
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(k, -4096);
    commit = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) sa(-262144, longint'(k) <<< 30);
    drain();
    chk("a_extreme_last", a_fo, 64'sd17179869184);

    // Reset one cycle after an accepted sample discards it and restores impulse bank
    fin = 19'sd50;
    ca  = 1'b0;
    va  = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_vo", a_vo, 0);
    chk("midrst_fo", a_fo, 0);
    tick();
    chk("midrst_vo_late", a_vo, 0);
    chk("midrst_fo_late", a_fo, 0);
    sa(9, 9);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fir_filter_mc.md
Name: fir_filter_mc

Overview:
- Parametrised, multi-channel successor to the fixed 19-bit-in / 36-bit-out FIR filter. Signed direct-form FIR with TAPS taps and NUM_CH time-interleaved channels.
- Each channel has its own delay line. All channels share one runtime-loadable coefficient set that is double-buffered (shadow/active).
- Sits between the sample source and downstream decimation/post-processing. Accepts up to one sample per clock; fixed 2-cycle latency.

Parameters:
- DATA_W, 19, signed input sample width
- COEF_W, 13, signed coefficient width
- TAPS, 16, number of taps (>=2)
- NUM_CH, 1, number of interleaved channels (>=1)
- CH_W, 1, width of channel index ports; must satisfy 2^CH_W >= NUM_CH
- OUT_W, DATA_W+COEF_W+clog2(TAPS) = 36, output width, full precision

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- FilterIn  in  DATA_W  signed input sample
- ValidIn  in  1  sample qualifier
- ChanIn  in  CH_W  channel of FilterIn
- CoefWrEn  in  1  shadow-bank write strobe
- CoefAddr  in  clog2(TAPS)  tap index for write
- CoefData  in  COEF_W  signed coefficient value
- CoefCommit  in  1  copy shadow bank to active bank
- FilterOut  out  OUT_W  signed filter result
- ValidOut  out  1  result qualifier
- ChanOut  out  CH_W  channel of FilterOut

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high.
  - Clears all delay lines and pipeline registers.
  - FilterOut=0, ValidOut=0, ChanOut=0.
  - Shadow and active banks both reset to an impulse: c[0]=1, c[1..TAPS-1]=0, so the filter is a pass-through.
- Reset mid-operation: in-flight results are discarded; ValidOut is low on the cycle after the rst edge.
- Acceptance: a sample is accepted at an edge where ValidIn=1, rst=0 and ChanIn<NUM_CH.
  - ChanIn>=NUM_CH: sample dropped; no state change; no ValidOut.
- Delay line: on acceptance, line[ChanIn] shifts; x[0] <= FilterIn. Other channels are untouched. ValidIn=0 changes no delay line.
- Arithmetic: y = sum over k=0..TAPS-1 of c[k]*x[k], evaluated on the accepted channel after the shift.
  - Signed two's complement, full precision, no rounding or saturation; overflow is impossible by the width rule.
- Pipeline:
  - Stage 1 registers the TAPS products and the channel tag at edge T+1.
  - Stage 2 registers the sum at edge T+2.
  - FilterOut, ChanOut and ValidOut=1 are valid for exactly one cycle after edge T+2.
  - Back-to-back samples produce back-to-back outputs; no stalls and no backpressure.
- Hold behaviour: when ValidOut=0, FilterOut and ChanOut hold their last value.
- Coefficients:
  - CoefWrEn with CoefAddr<TAPS writes shadow[CoefAddr] at the edge; CoefAddr>=TAPS is ignored.
  - The active bank is unaffected by writes until CoefCommit.
  - CoefCommit copies the whole shadow bank to the active bank at the edge.
  - If CoefWrEn and CoefCommit occur in the same cycle, the commit copies the shadow bank including the write made at that edge.
- Coefficient timing: a sample accepted at edge T uses the active bank as it stands after edge T.
  - A commit coincident with acceptance applies to that sample.
  - A commit at T+1 applies only to later samples, including samples already in the delay line.
- Delay-line preservation: commit does not clear delay lines.

Test Plan:
- Reset pass-through (NUM_CH=1): after reset, samples 5, -3, 262143 on consecutive cycles -> FilterOut 5, -3, 262143 on consecutive cycles, each first valid 2 cycles after its input; ValidOut high for exactly 3 cycles.
- Coefficient load: write c0=1, c1=2, c2=-3, others 0; commit; then impulse 100 followed by zeros -> outputs 100, 200, -300, 0, 0.
- Shadow isolation: write c0=7 without commit, then sample 4 -> output 4. Then commit in the same cycle as sample 4 -> output 28.
- Channel isolation (NUM_CH=3, CH_W=2): coefficients 1,1,1,0..., interleave ch0=10, ch1=0, ch2=0 repeated -> ch0 outputs 10, 20, 30, 30; ch1 and ch2 outputs 0; ChanIn=3 samples produce no ValidOut.
- Extreme values: all 16 coefficients -4096, 16 samples of -262144 -> 16th output equals 17179869184 (2^34); no wrap.
- Reset mid-stream: assert rst one cycle after an accepted sample -> no ValidOut from that sample; FilterOut=0. The next sample 9 after reset -> output 9 (impulse bank restored).
